fifo_rd: RTL and testbench

FIFO_RD -- requirements
Module: fifo_rd

---
 rtl/fifo_rd.sv | 104 ++++++++++
 tb/tb_fifo_rd.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd.sv
// fifo_rd: drains a FIFO in bursts once it reports full. Every word read is
// checked against an incrementing reference sequence that starts at EXP_INIT,
// and the block keeps a saturating error count, a sticky error flag and a
// count of completed bursts.
module fifo_rd #(
  parameter logic [7:0] EXP_INIT = 8'd0,
  parameter int         RD_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdempty,
  input  logic        rdfull,
  input  logic [7:0]  rddata,
  output logic        rdreq,
  output logic [7:0]  data,
  output logic        data_vld,
  output logic [7:0]  err_cnt,
  output logic        err_flag,
  output logic [15:0] burst_cnt,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    READ   = 2'b01,
    DRAIN  = 2'b10,
    FINISH = 2'b11
  } state_t;

  state_t            state;
  logic [RD_LAT-1:0] rd_pipe;
  logic              rd_vld;
  logic [7:0]        exp_val;

  // DRAIN waits a single cycle, so the read-valid delay line is only correct
  // for a one-cycle FIFO read latency.
  assign rd_vld = rd_pipe[RD_LAT-1];

  // Requests go out only in READ and never while the FIFO reports empty.
  assign rdreq = (state == READ) && !rdempty;

  // Burst sequencing, read-valid pipeline, data capture and checking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_pipe   <= '0;
      exp_val   <= EXP_INIT;
      data      <= '0;
      data_vld  <= 1'b0;
      err_cnt   <= '0;
      err_flag  <= 1'b0;
      burst_cnt <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (rdfull) begin
            state   <= READ;
            exp_val <= EXP_INIT;
          end
        end
        READ: begin
          // rdfull is deliberately ignored here; only empty ends the burst.
          if (rdempty) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // done and burst_cnt are registered so both are visible during FINISH.
          state     <= FINISH;
          done      <= 1'b1;
          burst_cnt <= burst_cnt + 16'd1;
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      rd_pipe[0] <= rdreq;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end

      data_vld <= rd_vld;
      if (rd_vld) begin
        data <= rddata;
        if (rddata != exp_val) begin
          err_flag <= 1'b1;
          if (err_cnt != '1) begin
            err_cnt <= err_cnt + 8'd1;
          end
        end
        // The reference keeps counting on its own even after a mismatch.
        exp_val <= exp_val + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd.sv
// tb_fifo_rd: bench for fifo_rd. A queue-based FIFO model feeds the DUT,
// expected words are queued when a burst is loaded and a monitor compares
// them as data_vld strobes arrive. Burst-level results (latency, counts,
// error status) come from simple arithmetic over the loaded words.
module tb_fifo_rd;

  localparam logic [7:0] EXP = 8'd0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdempty = 1'b1;
  logic        rdfull = 1'b0;
  logic [7:0]  rddata = 8'd0;
  logic        rdreq;
  logic [7:0]  data;
  logic        data_vld;
  logic [7:0]  err_cnt;
  logic        err_flag;
  logic [15:0] burst_cnt;
  logic        done;

  fifo_rd #(.EXP_INIT(EXP), .RD_LAT(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rdempty  (rdempty),
    .rdfull   (rdfull),
    .rddata   (rddata),
    .rdreq    (rdreq),
    .data     (data),
    .data_vld (data_vld),
    .err_cnt  (err_cnt),
    .err_flag (err_flag),
    .burst_cnt(burst_cnt),
    .done     (done)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic [7:0] q[$];
  logic [7:0] exp_q[$];
  logic [7:0] wbuf[$];
  bit         glitch_full = 1'b0;

  int vld_seen = 0;
  int done_evt = 0;
  int done_cyc = 0;
  logic prev_done = 1'b0;

  int err_total = 0;
  int model_burst = 0;

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: one-cycle read latency; also guards the no-read-while-empty rule.
  always @(posedge clk) begin
    check("rdreq_while_empty", int'(rdreq & rdempty), 0);
    if (rdreq && q.size() > 0) rddata <= q.pop_front();
  end

  // Flags change mid-cycle so they are stable around every rising edge.
  always @(negedge clk) begin
    rdempty = (q.size() == 0);
    rdfull  = (q.size() >= 256) || glitch_full;
  end

  // Monitor: scoreboard pop on every data strobe; done must never repeat.
  always @(negedge clk) begin
    if (data_vld) begin
      if (exp_q.size() == 0) check("unexpected_vld", 1, 0);
      else check("data", int'(data), int'(exp_q.pop_front()));
      vld_seen++;
    end
    if (done) begin
      check("done_consecutive", int'(prev_done), 0);
      done_cyc = cyc;
      done_evt++;
    end
    prev_done = done;
  end

  function automatic int sat_err();
    return (err_total > 255) ? 255 : err_total;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, int'(data), 0);
    check({tag, "_data_vld"}, int'(data_vld), 0);
    check({tag, "_err_cnt"}, int'(err_cnt), 0);
    check({tag, "_err_flag"}, int'(err_flag), 0);
    check({tag, "_burst_cnt"}, int'(burst_cnt), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_rdreq"}, int'(rdreq), 0);
  endtask

  // Build a burst of n reference words with ncorr distinct corrupted positions.
  task automatic make_words(input int n, input int ncorr);
    int idx;
    logic [7:0] good;
    wbuf.delete();
    for (int i = 0; i < n; i++) wbuf.push_back(8'(EXP + i));
    for (int c = 0; c < ncorr; c++) begin
      do begin
        idx = $urandom_range(n - 1, 0);
        good = 8'(EXP + idx);
      end while (wbuf[idx] != good);
      wbuf[idx] = wbuf[idx] ^ 8'($urandom_range(255, 1));
    end
  endtask

  task automatic load_words();
    foreach (wbuf[i]) begin
      q.push_back(wbuf[i]);
      exp_q.push_back(wbuf[i]);
      if (wbuf[i] != 8'(EXP + i)) err_total++;
    end
  endtask

  // Called just after a rising edge with the DUT idle.
  task automatic run_burst(input bit glitch);
    int n, start, snap, vbase;
    n = wbuf.size();
    snap = done_evt;
    vbase = vld_seen;
    load_words();
    if (glitch) glitch_full = 1'b1;
    start = cyc;
    if (glitch) begin
      @(posedge clk);
      #2 glitch_full = 1'b0;
    end
    while (done_evt == snap && (cyc - start) < n + 20) @(negedge clk);
    @(posedge clk);
    #2;
    model_burst++;
    check("done_seen", int'(done_evt != snap), 1);
    if (done_evt != snap) check("done_latency", done_cyc - start, n + 3);
    check("vld_count", vld_seen - vbase, n);
    check("burst_cnt", int'(burst_cnt), model_burst & 16'hFFFF);
    check("err_cnt", int'(err_cnt), sat_err());
    check("err_flag", int'(err_flag), int'(err_total > 0));
    check("leftover", exp_q.size(), 0);
  endtask

  task automatic idle_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    q.delete();
    exp_q.delete();
    err_total = 0;
    model_burst = 0;
  endtask

  initial begin
    int vbase, snap, t;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Full clean burst of 256 words.
    make_words(256, 0);
    run_burst(1'b0);

    // Word 10 corrupted: exactly one error, later words still line up.
    make_words(256, 0);
    wbuf[10] = 8'hAA;
    run_burst(1'b0);

    // rdfull glitch while empty: zero reads, done after DRAIN/FINISH.
    make_words(0, 0);
    run_burst(1'b1);

    // Random short bursts with random corruption.
    for (int b = 0; b < 8; b++) begin
      int n;
      n = $urandom_range(40, 1);
      make_words(n, $urandom_range(2, 0));
      run_burst(1'b1);
    end

    // Reset during a burst around word 100.
    make_words(256, 0);
    vbase = vld_seen;
    snap = done_evt;
    load_words();
    t = 0;
    while (vld_seen - vbase < 100 && t < 400) begin
      @(posedge clk);
      t++;
    end
    check("reach_word_100", int'(vld_seen - vbase >= 100), 1);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    q.delete();
    exp_q.delete();
    err_total = 0;
    model_burst = 0;
    @(negedge clk);
    check_reset_outputs("midreset");
    repeat (6) @(posedge clk);
    #2;
    check("no_done_after_abort", done_evt - snap, 0);
    make_words(256, 0);
    run_burst(1'b0);

    // 300 bursts with 3 corrupted words each: err_cnt saturates at 255.
    idle_reset();
    for (int b = 0; b < 300; b++) begin
      make_words(256, 3);
      run_burst(1'b0);
    end
    check("final_burst_cnt", int'(burst_cnt), 300);
    check("final_err_cnt", int'(err_cnt), 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
